// File: rtl/nanov_alu_seq.sv
// nanov_alu_seq: bit-serial operand sequencer for the nanoV 1-bit ALU.
// Latches two WIDTH-bit operands and a 4-bit opcode, streams them LSB-first
// into the serial ALU, carries between bits, and collects the result bits.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   start, op, a_in, b_in  request (accepted when not busy) with its operands
//   busy, done, result     status and completed result
//   alu_op/alu_a/alu_b/alu_cy_in   drive to the serial ALU (from registers only)
//   alu_d/alu_cy_out/alu_lts       returned from the serial ALU
module nanov_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cy_in,
  input  logic             alu_d,
  input  logic             alu_cy_out,
  input  logic             alu_lts
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cy_q, cy_d;
  logic               cmp_q, cmp_d;

  logic               accept;
  logic               last_bit;
  logic               is_cmp;

  // New request is taken in any state except RUN.
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  // SLT (010) and SLTU (011) return only the compare flag.
  assign is_cmp   = (op_q[2:1] == 2'b01);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs, decoded from the next state so they register in step
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // Operand/result shift datapath
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    cmp_d    = cmp_q;
    if (accept) begin
      a_sr_d = a_in;
      b_sr_d = b_in;
      op_d   = op;
      cnt_d  = '0;
      // Carry-in of 1 supplies the +1 of the two's-complement subtract.
      cy_d   = op[1] | op[3];
    end else if (state_q == S_RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = {alu_d, res_sr_q[WIDTH-1:1]};
      cy_d     = alu_cy_out;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_bit) begin
        cnt_d = '0;
        // SLTU: no carry out of a + ~b + 1 means a < b (unsigned).
        if (is_cmp) begin
          cmp_d = op_q[0] ? ~alu_cy_out : alu_lts;
        end else begin
          cmp_d = 1'b0;
        end
      end
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      cmp_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      cmp_q    <= cmp_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = is_cmp ? {{(WIDTH-1){1'b0}}, cmp_q} : res_sr_q;
  assign alu_op    = op_q;
  assign alu_a     = a_sr_q[0];
  assign alu_b     = b_sr_q[0];
  assign alu_cy_in = cy_q;

endmodule
